fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the N-lane in-order pipeline. It sits beside the ID/EX register. It keeps a shift-register scoreboard of in-flight destination registers, one entry per lane per tracked stage. For the bundle leaving ID it produces registered operand-forwarding selects, a combinational load-use stall, and the forwarded N flag.

---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_match.sv | 35 +++
 rtl/fwd_scoreboard.sv | 124 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - scoreboard entry type and forwarding-code helpers (FWD_FLAG_EN adds N-flag fields)
package fwd_pkg;

    localparam int RD_W   = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            load;
`ifdef FWD_FLAG_EN
        logic            nwe;
        logic            nval;
`endif
    } sb_entry_t;

    function automatic int fwd_code(input int stage, input int lane, input int lanes);
        return stage * lanes + lane + 1;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - forwarding code and load-use hit for one ID source operand
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int LANES  = 2,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 3
) (
    input  logic [REG_AW-1:0] i_src,
    input  sb_entry_t         i_sb [DEPTH][LANES],
    output logic [SEL_W-1:0]  o_code,
    output logic              o_load_hit
);

    always_comb begin
        o_code     = SEL_W'(FWD_RF);
        o_load_hit = 1'b0;
        if (i_src != '0) begin
            // Later writes win: walk oldest stage first, lanes ascending.
            for (int s = DEPTH - 2; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (i_sb[s][l].valid && i_sb[s][l].we && i_sb[s][l].rd == RD_W'(i_src))
                        o_code = SEL_W'(fwd_code(s, l, LANES));
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (i_sb[0][l].valid && i_sb[0][l].we && i_sb[0][l].load &&
                    i_sb[0][l].rd == RD_W'(i_src))
                    o_load_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - N-lane forwarding/hazard scoreboard beside ID/EX (FWD_FLAG_EN enables N-flag forwarding)
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int LANES  = 2,
    parameter int DEPTH  = 3,
    localparam int SEL_W = $clog2((DEPTH - 1) * LANES + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_hold,
    input  logic [LANES-1:0]            i_id_valid,
    input  logic [LANES*REG_AW-1:0]     i_id_rd,
    input  logic [LANES-1:0]            i_id_we,
    input  logic [LANES-1:0]            i_id_load,
    input  logic [LANES*2*REG_AW-1:0]   i_id_src,
    input  logic [LANES-1:0]            i_id_nwe,
    input  logic [LANES-1:0]            i_ex_n,
    output logic                        o_stall,
    output logic [LANES*2*SEL_W-1:0]    o_fwd_sel,
    output logic                        o_n_fwd
);

    sb_entry_t              r_sb [DEPTH][LANES];
    sb_entry_t              w_new [LANES];
    logic [LANES*2*SEL_W-1:0] r_fwd_sel;
    logic [SEL_W-1:0]       w_code [LANES*2];
    logic [LANES*2-1:0]     w_hit;
    logic [LANES*2-1:0]     w_src_valid;

    for (genvar g = 0; g < LANES * 2; g++) begin : g_match
        assign w_src_valid[g] = i_id_valid[g / 2];
        fwd_match #(
            .REG_AW (REG_AW),
            .LANES  (LANES),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .i_src      (i_id_src[g*REG_AW +: REG_AW]),
            .i_sb       (r_sb),
            .o_code     (w_code[g]),
            .o_load_hit (w_hit[g])
        );
    end

    assign o_stall   = |(w_hit & w_src_valid);
    assign o_fwd_sel = r_fwd_sel;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_new[l]       = '0;
            w_new[l].rd    = RD_W'(i_id_rd[l*REG_AW +: REG_AW]);
            w_new[l].we    = i_id_we[l];
            w_new[l].load  = i_id_load[l];
`ifdef FWD_FLAG_EN
            w_new[l].nwe   = i_id_nwe[l];
            w_new[l].valid = i_id_valid[l] & (i_id_we[l] | i_id_nwe[l]);
`else
            w_new[l].valid = i_id_valid[l] & i_id_we[l];
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < DEPTH; s++)
                for (int l = 0; l < LANES; l++)
                    r_sb[s][l] <= '0;
            r_fwd_sel <= '0;
        end else if (!i_hold) begin
            for (int s = DEPTH - 1; s > 0; s--)
                for (int l = 0; l < LANES; l++)
                    r_sb[s][l] <= r_sb[s-1][l];
`ifdef FWD_FLAG_EN
            // N is only known once the instruction has been through EX.
            for (int l = 0; l < LANES; l++)
                r_sb[1][l].nval <= i_ex_n[l];
`endif
            for (int l = 0; l < LANES; l++) begin
                if (o_stall)
                    r_sb[0][l] <= '0;
                else
                    r_sb[0][l] <= w_new[l];
            end
            if (o_stall) begin
                r_fwd_sel <= '0;
            end else begin
                for (int g = 0; g < LANES * 2; g++)
                    r_fwd_sel[g*SEL_W +: SEL_W] <= w_code[g];
            end
        end
    end

`ifdef FWD_FLAG_EN
    logic r_n_arch;
    logic w_n_fwd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_n_arch <= 1'b0;
        end else if (!i_hold) begin
            for (int l = 0; l < LANES; l++)
                if (r_sb[DEPTH-1][l].valid && r_sb[DEPTH-1][l].nwe)
                    r_n_arch <= r_sb[DEPTH-1][l].nval;
        end
    end

    always_comb begin
        w_n_fwd = r_n_arch;
        for (int s = DEPTH - 1; s >= 1; s--)
            for (int l = 0; l < LANES; l++)
                if (r_sb[s][l].valid && r_sb[s][l].nwe)
                    w_n_fwd = r_sb[s][l].nval;
    end

    assign o_n_fwd = w_n_fwd;
`else
    logic w_unused_flag;
    assign w_unused_flag = ^{i_id_nwe, i_ex_n};
    assign o_n_fwd       = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed-vector bench for fwd_scoreboard (FWD_FLAG_EN selects flag expectations)
module tb_fwd_scoreboard;

    localparam int REG_AW = 3;
    localparam int LANES  = 2;
    localparam int DEPTH  = 3;
    localparam int SEL_W  = 3;
`ifdef FWD_FLAG_EN
    localparam logic FLAG = 1'b1;
`else
    localparam logic FLAG = 1'b0;
`endif

    logic                      i_clk = 1'b0;
    logic                      i_rst;
    logic                      i_hold;
    logic [LANES-1:0]          i_id_valid;
    logic [LANES*REG_AW-1:0]   i_id_rd;
    logic [LANES-1:0]          i_id_we;
    logic [LANES-1:0]          i_id_load;
    logic [LANES*2*REG_AW-1:0] i_id_src;
    logic [LANES-1:0]          i_id_nwe;
    logic [LANES-1:0]          i_ex_n;
    logic                      o_stall;
    logic [LANES*2*SEL_W-1:0]  o_fwd_sel;
    logic                      o_n_fwd;

    int n_vec = 0;
    int n_err = 0;

    fwd_scoreboard #(.REG_AW(REG_AW), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_hold     (i_hold),
        .i_id_valid (i_id_valid),
        .i_id_rd    (i_id_rd),
        .i_id_we    (i_id_we),
        .i_id_load  (i_id_load),
        .i_id_src   (i_id_src),
        .i_id_nwe   (i_id_nwe),
        .i_ex_n     (i_ex_n),
        .o_stall    (o_stall),
        .o_fwd_sel  (o_fwd_sel),
        .o_n_fwd    (o_n_fwd)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    function automatic logic [SEL_W-1:0] sel(input int op);
        return o_fwd_sel[op*SEL_W +: SEL_W];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_id();
        i_id_valid = '0; i_id_rd = '0; i_id_we = '0; i_id_load = '0;
        i_id_src = '0; i_id_nwe = '0; i_ex_n = '0;
    endtask

    task automatic put(input int l, input int rd, input bit we, input bit ld,
                       input int s0, input int s1, input bit nwe);
        i_id_valid[l] = 1'b1;
        i_id_rd[l*REG_AW +: REG_AW] = rd[REG_AW-1:0];
        i_id_we[l] = we;
        i_id_load[l] = ld;
        i_id_src[(2*l)*REG_AW +: REG_AW] = s0[REG_AW-1:0];
        i_id_src[(2*l+1)*REG_AW +: REG_AW] = s1[REG_AW-1:0];
        i_id_nwe[l] = nwe;
    endtask

    task automatic flush();
        clr_id();
        repeat (DEPTH) tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_hold = 1'b0; clr_id();
        tick(); tick();
        n_vec++; if (o_fwd_sel !== '0) begin n_err++; $display("FAIL rst_sel got %h exp 0", o_fwd_sel); end
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", o_stall); end
        n_vec++; if (o_n_fwd !== 1'b0) begin n_err++; $display("FAIL rst_nfwd got %b exp 0", o_n_fwd); end
        i_rst = 1'b0;
        put(0, 6, 1, 0, 0, 0, 1);
        tick();
        clr_id(); put(0, 0, 0, 0, 6, 0, 0); put(1, 2, 1, 1, 0, 0, 0); i_ex_n = 2'b01;
        tick();
        n_vec++; if (sel(0) !== 3'd1) begin n_err++; $display("FAIL rst_pre_sel got %0d exp 1", sel(0)); end
        n_vec++; if (o_n_fwd !== FLAG) begin n_err++; $display("FAIL rst_pre_nfwd got %b exp %b", o_n_fwd, FLAG); end
        clr_id(); put(0, 0, 0, 0, 2, 0, 0);
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall got %b exp 1", o_stall); end
        #1 i_rst = 1'b1;
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got %b exp 0", o_stall); end
        n_vec++; if (o_fwd_sel !== '0) begin n_err++; $display("FAIL rst_mid_sel got %h exp 0", o_fwd_sel); end
        n_vec++; if (o_n_fwd !== 1'b0) begin n_err++; $display("FAIL rst_mid_nfwd got %b exp 0", o_n_fwd); end
        #1 i_rst = 1'b0;
        tick();
        n_vec++; if (sel(0) !== 3'd0) begin n_err++; $display("FAIL rst_after_sel got %0d exp 0", sel(0)); end
        flush();
    endtask

    task automatic test_ex_to_ex();
        put(1, 3, 1, 0, 0, 0, 0);
        tick();
        clr_id(); put(0, 0, 0, 0, 3, 0, 0);
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL ex2ex_stall got %b exp 0", o_stall); end
        tick();
        n_vec++; if (sel(0) !== 3'd2) begin n_err++; $display("FAIL ex2ex_sel0 got %0d exp 2", sel(0)); end
        n_vec++; if (sel(1) !== 3'd0) begin n_err++; $display("FAIL ex2ex_sel1 got %0d exp 0", sel(1)); end
        flush();
    endtask

    task automatic test_youngest();
        put(0, 5, 1, 0, 0, 0, 0); put(1, 5, 1, 0, 0, 0, 0);
        tick();
        clr_id(); put(0, 0, 1, 0, 0, 0, 0);
        tick();
        clr_id(); put(0, 0, 0, 0, 5, 0, 0); put(1, 0, 0, 0, 5, 0, 0);
        tick();
        n_vec++; if (sel(0) !== 3'd4) begin n_err++; $display("FAIL young_sel0 got %0d exp 4", sel(0)); end
        n_vec++; if (sel(1) !== 3'd0) begin n_err++; $display("FAIL young_r0 got %0d exp 0", sel(1)); end
        n_vec++; if (sel(2) !== 3'd4) begin n_err++; $display("FAIL young_sel2 got %0d exp 4", sel(2)); end
        n_vec++; if (sel(3) !== 3'd0) begin n_err++; $display("FAIL young_sel3 got %0d exp 0", sel(3)); end
        flush();
    endtask

    task automatic test_stage_priority();
        put(0, 7, 1, 0, 0, 0, 0); put(1, 7, 1, 0, 0, 0, 0);
        tick();
        clr_id(); put(0, 7, 1, 0, 0, 0, 0); put(1, 1, 1, 0, 0, 0, 0);
        tick();
        clr_id(); put(0, 0, 0, 0, 7, 0, 0);
        tick();
        n_vec++; if (sel(0) !== 3'd1) begin n_err++; $display("FAIL prio_stage got %0d exp 1", sel(0)); end
        clr_id();
        tick();
        put(1, 0, 0, 0, 0, 1, 0);
        tick();
        n_vec++; if (sel(3) !== 3'd0) begin n_err++; $display("FAIL wb_excluded got %0d exp 0", sel(3)); end
        flush();
    endtask

    task automatic test_load_use();
        put(1, 6, 1, 0, 0, 0, 0);
        tick();
        clr_id(); put(0, 2, 1, 1, 0, 0, 0); put(1, 0, 0, 0, 6, 0, 0);
        tick();
        n_vec++; if (sel(2) !== 3'd2) begin n_err++; $display("FAIL lu_pre_sel got %0d exp 2", sel(2)); end
        clr_id(); put(0, 0, 0, 0, 2, 0, 0); put(1, 0, 0, 0, 6, 0, 0);
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", o_stall); end
        tick();
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_clr got %b exp 0", o_stall); end
        n_vec++; if (o_fwd_sel !== '0) begin n_err++; $display("FAIL lu_bubble_sel got %h exp 0", o_fwd_sel); end
        tick();
        n_vec++; if (sel(0) !== 3'd3) begin n_err++; $display("FAIL lu_sel0 got %0d exp 3", sel(0)); end
        n_vec++; if (sel(2) !== 3'd0) begin n_err++; $display("FAIL lu_sel2 got %0d exp 0", sel(2)); end
        flush();
    endtask

    task automatic test_hold();
        put(0, 4, 1, 0, 0, 0, 0);
        tick();
        clr_id(); put(1, 0, 0, 0, 0, 4, 0); i_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (sel(3) !== 3'd0) begin n_err++; $display("FAIL hold_sel cyc%0d got %0d exp 0", i, sel(3)); end
        end
        i_hold = 1'b0;
        tick();
        n_vec++; if (sel(3) !== 3'd1) begin n_err++; $display("FAIL hold_resume got %0d exp 1", sel(3)); end
        flush();
    endtask

    task automatic test_hold_stall();
        put(1, 2, 1, 1, 0, 0, 0);
        tick();
        clr_id(); put(0, 0, 0, 0, 2, 0, 0); i_hold = 1'b1;
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL hs_stall0 got %b exp 1", o_stall); end
        tick();
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL hs_stall1 got %b exp 1", o_stall); end
        i_hold = 1'b0;
        tick();
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL hs_stall2 got %b exp 0", o_stall); end
        tick();
        n_vec++; if (sel(0) !== 3'd4) begin n_err++; $display("FAIL hs_sel0 got %0d exp 4", sel(0)); end
        flush();
    endtask

    task automatic test_flag();
        put(0, 0, 0, 0, 0, 0, 1);
        tick();
        clr_id(); i_ex_n = 2'b01;
        #1;
        n_vec++; if (o_n_fwd !== 1'b0) begin n_err++; $display("FAIL flag_ex got %b exp 0", o_n_fwd); end
        tick();
        i_ex_n = 2'b00;
        n_vec++; if (o_n_fwd !== FLAG) begin n_err++; $display("FAIL flag_s1 got %b exp %b", o_n_fwd, FLAG); end
        tick(); tick();
        n_vec++; if (o_n_fwd !== FLAG) begin n_err++; $display("FAIL flag_arch got %b exp %b", o_n_fwd, FLAG); end
        put(0, 0, 0, 0, 0, 0, 1); put(1, 0, 0, 0, 0, 0, 1);
        tick();
        clr_id(); i_ex_n = 2'b01;
        tick();
        i_ex_n = 2'b00;
        n_vec++; if (o_n_fwd !== 1'b0) begin n_err++; $display("FAIL flag_lane got %b exp 0", o_n_fwd); end
        flush();
        n_vec++; if (o_n_fwd !== 1'b0) begin n_err++; $display("FAIL flag_arch2 got %b exp 0", o_n_fwd); end
    endtask

    initial begin
        test_reset();
        test_ex_to_ex();
        test_youngest();
        test_stage_priority();
        test_load_use();
        test_hold();
        test_hold_stall();
        test_flag();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
